// File: rtl/pipe_alu_mem_p.sv
`default_nettype none
// ==========================================================================
// pipe_alu_mem_p: four-stage ALU pipe with forwarding, register bank and result memory
// Rev 1.0
// ==========================================================================
module pipe_alu_mem_p #(
  parameter int unsigned DW     = 16,
  parameter int unsigned RW     = 4,
  parameter int unsigned AW     = 8,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [RW-1:0] rs1,
  input  logic [RW-1:0] rs2,
  input  logic [RW-1:0] rd,
  input  logic [3:0]    func,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] z,
  output logic          z_valid,
  output logic          zf,
  output logic          cf,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  localparam int NREG = 2**RW;
  localparam int NMEM = 2**AW;

  localparam logic [3:0] C_OP_ADD   = 4'd0;
  localparam logic [3:0] C_OP_SUB   = 4'd1;
  localparam logic [3:0] C_OP_MUL   = 4'd2;
  localparam logic [3:0] C_OP_PASSA = 4'd3;
  localparam logic [3:0] C_OP_PASSB = 4'd4;
  localparam logic [3:0] C_OP_AND   = 4'd5;
  localparam logic [3:0] C_OP_OR    = 4'd6;
  localparam logic [3:0] C_OP_XOR   = 4'd7;
  localparam logic [3:0] C_OP_NOTA  = 4'd8;
  localparam logic [3:0] C_OP_NOTB  = 4'd9;
  localparam logic [3:0] C_OP_SRL   = 4'd10;
  localparam logic [3:0] C_OP_SLL   = 4'd11;
  localparam logic [3:0] C_OP_SRA   = 4'd12;
  localparam logic [3:0] C_OP_SLTU  = 4'd13;
  localparam logic [3:0] C_OP_STORE = 4'd14;
  localparam logic [3:0] C_OP_LOADI = 4'd15;

  // Stage 1: operands read from the bank plus decoded instruction fields
  logic          s1_valid_q;
  logic [DW-1:0] s1_a_q, s1_b_q;
  logic [RW-1:0] s1_rs1_q, s1_rs2_q, s1_rd_q;
  logic [3:0]    s1_func_q;
  logic [AW-1:0] s1_addr_q;

  // Stage 2: executed result
  logic          s2_valid_q, s2_wreg_q, s2_wmem_q, s2_cf_q;
  logic [DW-1:0] s2_res_q;
  logic [RW-1:0] s2_rd_q;
  logic [AW-1:0] s2_addr_q;

  // Stage 3: architectural result, also feeds the memory write
  logic          s3_valid_q, s3_wreg_q, s3_wmem_q, s3_zf_q, s3_cf_q;
  logic [DW-1:0] s3_res_q;
  logic [RW-1:0] s3_rd_q;
  logic [AW-1:0] s3_addr_q;

  logic [DW-1:0] bank_q [NREG];
  logic [DW-1:0] mem_q  [NMEM];
  logic [DW-1:0] dbg_q;

  logic [DW-1:0] opa, opb, imm, res_d;
  logic          cf_d;
  logic [DW:0]   sum, diff;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q    <= bank_q[rs1];
        s1_b_q    <= bank_q[rs2];
        s1_rs1_q  <= rs1;
        s1_rs2_q  <= rs2;
        s1_rd_q   <= rd;
        s1_func_q <= func;
        s1_addr_q <= addr;
      end
    end
  end

  generate
    if (FWD_EN) begin : g_fwd
      // Stage 2 is the younger producer, so it overrides stage 3
      always_comb begin
        opa = s1_a_q;
        opb = s1_b_q;
        if (s3_valid_q && s3_wreg_q && (s3_rd_q == s1_rs1_q)) opa = s3_res_q;
        if (s3_valid_q && s3_wreg_q && (s3_rd_q == s1_rs2_q)) opb = s3_res_q;
        if (s2_valid_q && s2_wreg_q && (s2_rd_q == s1_rs1_q)) opa = s2_res_q;
        if (s2_valid_q && s2_wreg_q && (s2_rd_q == s1_rs2_q)) opb = s2_res_q;
      end
    end else begin : g_nofwd
      assign opa = s1_a_q;
      assign opb = s1_b_q;
    end

    if (AW >= DW) begin : g_imm_trunc
      assign imm = s1_addr_q[DW-1:0];
    end else begin : g_imm_zext
      assign imm = {{(DW-AW){1'b0}}, s1_addr_q};
    end
  endgenerate

  assign sum  = {1'b0, opa} + {1'b0, opb};
  assign diff = {1'b0, opa} - {1'b0, opb};

  always_comb begin
    res_d = opa;
    cf_d  = 1'b0;
    case (s1_func_q)
      C_OP_ADD:   begin res_d = sum[DW-1:0];  cf_d = sum[DW];  end
      C_OP_SUB:   begin res_d = diff[DW-1:0]; cf_d = diff[DW]; end
      C_OP_MUL:   res_d = opa * opb;
      C_OP_PASSA: res_d = opa;
      C_OP_PASSB: res_d = opb;
      C_OP_AND:   res_d = opa & opb;
      C_OP_OR:    res_d = opa | opb;
      C_OP_XOR:   res_d = opa ^ opb;
      C_OP_NOTA:  res_d = ~opa;
      C_OP_NOTB:  res_d = ~opb;
      C_OP_SRL:   res_d = opa >> 1;
      C_OP_SLL:   res_d = opa << 1;
      C_OP_SRA:   res_d = {opa[DW-1], opa[DW-1:1]};
      C_OP_SLTU:  res_d = {{(DW-1){1'b0}}, diff[DW]};
      C_OP_STORE: res_d = opa;
      C_OP_LOADI: res_d = imm;
      default:    res_d = opa;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_res_q  <= res_d;
        s2_cf_q   <= cf_d;
        s2_rd_q   <= s1_rd_q;
        s2_addr_q <= s1_addr_q;
        s2_wreg_q <= (s1_func_q != C_OP_STORE);
        s2_wmem_q <= (s1_func_q != C_OP_LOADI);
      end
    end
  end

  // Bubbles leave z/zf/cf holding their last values
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid_q <= 1'b0;
      s3_res_q   <= '0;
      s3_zf_q    <= 1'b0;
      s3_cf_q    <= 1'b0;
    end else begin
      s3_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        s3_res_q  <= s2_res_q;
        s3_zf_q   <= (s2_res_q == '0);
        s3_cf_q   <= s2_cf_q;
        s3_rd_q   <= s2_rd_q;
        s3_addr_q <= s2_addr_q;
        s3_wreg_q <= s2_wreg_q;
        s3_wmem_q <= s2_wmem_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) bank_q[i] <= '0;
    end else if (s2_valid_q && s2_wreg_q) begin
      bank_q[s2_rd_q] <= s2_res_q;
    end
  end

  // Memory contents survive reset; only the write is suppressed
  always_ff @(posedge clk) begin
    if (!rst && s3_valid_q && s3_wmem_q) mem_q[s3_addr_q] <= s3_res_q;
  end

  always_ff @(posedge clk) begin
    if (rst) dbg_q <= '0;
    else     dbg_q <= mem_q[dbg_addr];
  end

  assign z        = s3_res_q;
  assign z_valid  = s3_valid_q;
  assign zf       = s3_zf_q;
  assign cf       = s3_cf_q;
  assign dbg_data = dbg_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_alu_mem_p.sv
`default_nettype none
// ==========================================================================
// tb_pipe_alu_mem_p: table, directed and random checks of pipe_alu_mem_p (forwarding and non-forwarding)
// Rev 1.0
// ==========================================================================
module tb_pipe_alu_mem_p;

  localparam int DW = 16;
  localparam int RW = 4;
  localparam int AW = 8;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_MUL = 4'd2,  OP_PASSA = 4'd3;
  localparam logic [3:0] OP_PASSB = 4'd4, OP_AND = 4'd5, OP_OR = 4'd6,  OP_XOR = 4'd7;
  localparam logic [3:0] OP_NOTA = 4'd8, OP_NOTB = 4'd9, OP_SRL = 4'd10, OP_SLL = 4'd11;
  localparam logic [3:0] OP_SRA = 4'd12, OP_SLTU = 4'd13, OP_STORE = 4'd14, OP_LOADI = 4'd15;

  logic          clk = 1'b0;
  logic          rst, in_valid;
  logic [RW-1:0] rs1, rs2, rd;
  logic [3:0]    func;
  logic [AW-1:0] addr, dbg_addr;
  logic [DW-1:0] z1, z0, dbg1, dbg0;
  logic          zv1, zf1, cf1, zv0, zf0, cf0;

  always #5 clk = ~clk;

  pipe_alu_mem_p #(.DW(DW), .RW(RW), .AW(AW), .FWD_EN(1'b1)) u_fwd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
    .func(func), .addr(addr), .z(z1), .z_valid(zv1), .zf(zf1), .cf(cf1),
    .dbg_addr(dbg_addr), .dbg_data(dbg1));

  pipe_alu_mem_p #(.DW(DW), .RW(RW), .AW(AW), .FWD_EN(1'b0)) u_nofwd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
    .func(func), .addr(addr), .z(z0), .z_valid(zv0), .zf(zf0), .cf(cf0),
    .dbg_addr(dbg_addr), .dbg_data(dbg0));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Reference ALU written directly from the opcode table
  function automatic void alu(input logic [3:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic [AW-1:0] im, output logic [DW-1:0] r, output bit c);
    logic [DW:0] w;
    c = 1'b0;
    case (f)
      OP_ADD:   begin w = {1'b0, a} + {1'b0, b}; r = w[DW-1:0]; c = w[DW]; end
      OP_SUB:   begin r = a - b; c = (a < b); end
      OP_MUL:   r = a * b;
      OP_PASSA: r = a;
      OP_PASSB: r = b;
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NOTA:  r = ~a;
      OP_NOTB:  r = ~b;
      OP_SRL:   r = a >> 1;
      OP_SLL:   r = a << 1;
      OP_SRA:   r = $unsigned($signed(a) >>> 1);
      OP_SLTU:  r = (a < b) ? 16'd1 : 16'd0;
      OP_STORE: r = a;
      default:  r = {{(DW-AW){1'b0}}, im};
    endcase
  endfunction

  // Architectural model (forwarding DUT) and latency-aware bank model (non-forwarding DUT)
  typedef struct { bit v; logic [DW-1:0] z; bit c; } ex_t;
  logic [DW-1:0] m_reg [16];
  logic [DW-1:0] n_reg [16];
  logic [DW-1:0] m_mem [256];
  bit            m_known [256];
  ex_t           ef [2];
  ex_t           en [2];
  bit            mw_v [3];
  logic [AW-1:0] mw_a [3];
  logic [DW-1:0] mw_d [3];
  bit            nw_v [2];
  logic [RW-1:0] nw_r [2];
  logic [DW-1:0] nw_d [2];
  logic [DW-1:0] h_z1, h_z0;
  bit            h_zf1, h_cf1, h_zf0, h_cf0;

  task automatic step(input bit v, input logic [3:0] f, input logic [RW-1:0] d,
                      input logic [RW-1:0] s1, input logic [RW-1:0] s2,
                      input logic [AW-1:0] a, input bit r);
    logic [DW-1:0] zm, zn, xdbg;
    bit            cm, cn, kdbg, ev1, ev0;
    ex_t           o1, o0;
    in_valid = v; func = f; rd = d; rs1 = s1; rs2 = s2; addr = a; rst = r;
    if (r) begin
      for (int i = 0; i < 16; i++) begin m_reg[i] = '0; n_reg[i] = '0; end
      for (int j = 0; j < 2; j++) begin ef[j].v = 0; en[j].v = 0; nw_v[j] = 0; end
      for (int j = 0; j < 3; j++) mw_v[j] = 0;
      h_z1 = '0; h_zf1 = 0; h_cf1 = 0; h_z0 = '0; h_zf0 = 0; h_cf0 = 0;
      ev1 = 0; ev0 = 0; xdbg = '0; kdbg = 1;
    end else begin
      alu(f, m_reg[s1], m_reg[s2], a, zm, cm);
      alu(f, n_reg[s1], n_reg[s2], a, zn, cn);
      if (v && f != OP_STORE) m_reg[d] = zm;
      if (nw_v[1]) n_reg[nw_r[1]] = nw_d[1];
      nw_v[1] = nw_v[0]; nw_r[1] = nw_r[0]; nw_d[1] = nw_d[0];
      nw_v[0] = v && (f != OP_STORE); nw_r[0] = d; nw_d[0] = zn;
      xdbg = m_mem[dbg_addr]; kdbg = m_known[dbg_addr];
      if (mw_v[2]) begin m_mem[mw_a[2]] = mw_d[2]; m_known[mw_a[2]] = 1; end
      for (int j = 2; j > 0; j--) begin mw_v[j] = mw_v[j-1]; mw_a[j] = mw_a[j-1]; mw_d[j] = mw_d[j-1]; end
      mw_v[0] = v && (f != OP_LOADI); mw_a[0] = a; mw_d[0] = zm;
      o1 = ef[1]; ef[1] = ef[0]; ef[0] = '{v, zm, cm};
      o0 = en[1]; en[1] = en[0]; en[0] = '{v, zn, cn};
      ev1 = o1.v; ev0 = o0.v;
      if (o1.v) begin h_z1 = o1.z; h_zf1 = (o1.z == '0); h_cf1 = o1.c; end
      if (o0.v) begin h_z0 = o0.z; h_zf0 = (o0.z == '0); h_cf0 = o0.c; end
    end
    @(posedge clk); #1;
    chk("zvalid_fwd", zv1, ev1);
    chk("z_fwd", z1, h_z1);
    chk("zf_fwd", zf1, h_zf1);
    chk("cf_fwd", cf1, h_cf1);
    chk("zvalid_nofwd", zv0, ev0);
    chk("z_nofwd", z0, h_z0);
    chk("zf_nofwd", zf0, h_zf0);
    chk("cf_nofwd", cf0, h_cf0);
    if (kdbg) chk("dbg_data", dbg1, xdbg);
  endtask

  task automatic bubble(input logic [AW-1:0] a);
    step(0, OP_ADD, 4'd0, 4'd0, 4'd0, a, 0);
  endtask

  typedef struct {
    logic [3:0] f; logic [RW-1:0] d, s1, s2; logic [AW-1:0] a;
    logic [DW-1:0] ez; bit ezf, ecf;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] f, input int d, input int s1, input int s2,
                              input int a, input int ez, input bit ezf, input bit ecf);
    vec_t t;
    t.f = f; t.d = RW'(d); t.s1 = RW'(s1); t.s2 = RW'(s2); t.a = AW'(a);
    t.ez = DW'(ez); t.ezf = ezf; t.ecf = ecf;
    return t;
  endfunction

  vec_t tbl [25];

  initial begin
    tbl[0]  = mk(OP_LOADI, 1, 0, 0, 'h05, 'h0005, 0, 0);
    tbl[1]  = mk(OP_STORE, 3, 1, 0, 'h20, 'h0005, 0, 0);
    tbl[2]  = mk(OP_PASSA, 3, 3, 0, 'h32, 'h0000, 1, 0);
    tbl[3]  = mk(OP_LOADI, 2, 0, 0, 'h03, 'h0003, 0, 0);
    tbl[4]  = mk(OP_LOADI, 7, 0, 0, 'h01, 'h0001, 0, 0);
    tbl[5]  = mk(OP_NOTA,  6, 0, 0, 'h35, 'hFFFF, 0, 0);
    tbl[6]  = mk(OP_ADD,   8, 6, 7, 'h36, 'h0000, 1, 1);
    tbl[7]  = mk(OP_LOADI, 9, 0, 0, 'h02, 'h0002, 0, 0);
    tbl[8]  = mk(OP_SUB,  10, 9, 2, 'h38, 'hFFFF, 0, 1);
    tbl[9]  = mk(OP_SLTU,  4, 9, 2, 'h39, 'h0001, 0, 0);
    tbl[10] = mk(OP_SLTU,  4, 2, 9, 'h3A, 'h0000, 1, 0);
    tbl[11] = mk(OP_SLL,  11, 1, 0, 'h3B, 'h000A, 0, 0);
    tbl[12] = mk(OP_LOADI,12, 0, 0, 'h80, 'h0080, 0, 0);
    tbl[13] = mk(OP_MUL,  13,12,12, 'h3D, 'h4000, 0, 0);
    tbl[14] = mk(OP_SLL,  13,13, 0, 'h3E, 'h8000, 0, 0);
    tbl[15] = mk(OP_LOADI,14, 0, 0, 'h04, 'h0004, 0, 0);
    tbl[16] = mk(OP_OR,   13,13,14, 'h40, 'h8004, 0, 0);
    tbl[17] = mk(OP_SRA,  15,13, 0, 'h41, 'hC002, 0, 0);
    tbl[18] = mk(OP_SRL,   5,13, 0, 'h42, 'h4002, 0, 0);
    tbl[19] = mk(OP_XOR,   5, 1, 2, 'h43, 'h0006, 0, 0);
    tbl[20] = mk(OP_AND,   5, 1, 2, 'h44, 'h0001, 0, 0);
    tbl[21] = mk(OP_PASSB, 5, 0, 2, 'h45, 'h0003, 0, 0);
    tbl[22] = mk(OP_NOTB,  5, 0, 1, 'h46, 'hFFFA, 0, 0);
    tbl[23] = mk(OP_SUB,   5, 2, 9, 'h47, 'h0001, 0, 0);
    tbl[24] = mk(OP_ADD,   5, 1, 2, 'h48, 'h0008, 0, 0);

    dbg_addr = '0;
    step(0, OP_ADD, 0, 0, 0, 0, 1);
    step(0, OP_ADD, 0, 0, 0, 0, 1);

    // Back-to-back dependents: forwarding gives 8 then 3; without it both operands of ADD are stale
    step(1, OP_LOADI, 1, 0, 0, 8'h05, 0);
    step(1, OP_LOADI, 2, 0, 0, 8'h03, 0);
    step(1, OP_ADD,   3, 1, 2, 8'h10, 0);
    step(1, OP_SUB,   4, 3, 1, 8'h11, 0);
    bubble(8'h00);
    chk("seqA_add_z_fwd", z1, 16'h0008);
    chk("seqA_add_zv_fwd", zv1, 1'b1);
    chk("seqA_add_z_nofwd", z0, 16'h0000);
    bubble(8'h00);
    chk("seqA_sub_z_fwd", z1, 16'h0003);
    chk("seqA_sub_z_nofwd", z0, 16'hFFFB);
    dbg_addr = 8'h10;
    bubble(8'h00);
    chk("seqA_mem", dbg1, 16'h0008);
    step(0, OP_ADD, 0, 0, 0, 0, 1);

    // Isolated ops: two bubbles each, bubbles aimed at the STORE target address
    dbg_addr = 8'h20;
    for (int i = 0; i < 25; i++) begin
      step(1, tbl[i].f, tbl[i].d, tbl[i].s1, tbl[i].s2, tbl[i].a, 0);
      bubble(8'h20);
      bubble(8'h20);
      chk($sformatf("tbl%0d_z_fwd", i), z1, tbl[i].ez);
      chk($sformatf("tbl%0d_zf_fwd", i), zf1, tbl[i].ezf);
      chk($sformatf("tbl%0d_cf_fwd", i), cf1, tbl[i].ecf);
      chk($sformatf("tbl%0d_z_nofwd", i), z0, tbl[i].ez);
    end
    chk("bubble_mem", dbg1, 16'h0005);

    // Reset one cycle after issuing ADD r5: no bank or memory write survives
    step(1, OP_STORE, 0, 1, 0, 8'h60, 0);
    bubble(8'h00); bubble(8'h00); bubble(8'h00);
    dbg_addr = 8'h60;
    step(1, OP_ADD, 5, 1, 2, 8'h60, 0);
    step(0, OP_ADD, 0, 0, 0, 8'h00, 1);
    chk("rst_zv", zv1, 1'b0);
    chk("rst_z", z1, 16'h0000);
    bubble(8'h00); bubble(8'h00);
    step(1, OP_PASSA, 6, 5, 0, 8'h61, 0);
    bubble(8'h00); bubble(8'h00);
    chk("rst_r5_z", z1, 16'h0000);
    chk("rst_r5_zv", zv1, 1'b1);
    chk("rst_mem", dbg1, 16'h0005);

    for (int i = 0; i < 400; i++) begin
      dbg_addr = AW'($urandom_range(128, 255));
      step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), RW'($urandom_range(0, 5)),
           RW'($urandom_range(0, 5)), RW'($urandom_range(0, 5)), AW'($urandom_range(128, 255)),
           ($urandom_range(0, 63) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
